upcounter_arbiter: RTL and testbench
====================================

# upcounter_arbiter

- Shares one WIDTH-bit up-counting resource among N_REQ requesters.
- Each requester asks for a timed run to its own terminal count. The block arbitrates round-robin, runs the counter from 0 up to the winner's terminal count, then pulses a per-requester done.
- It is the scheduler in front of the up-counter datapath, so client logic never drives the counter directly.

## Interface
- N_REQ, default 4: number of requesters (2..8).
- WIDTH, default 4: counter and terminal-count width.
- clk  input  1: single clock, rising-edge.
- reset  input  1: asynchronous, active-low reset.
- req  input  N_REQ: per-requester run request, level; held until done.
- tc  input  N_REQ*WIDTH: terminal counts, requester i at bits [i*WIDTH +: WIDTH].
- grant  output  N_REQ: one-hot owner of counter; all-zero when free.
- busy  output  1: high in RUN and DONE.
- count  output  WIDTH: current counter value.
- done  output  N_REQ: one-cycle pulse to the finished requester.

## Operation
- Reset values (reset low, immediate): state=IDLE, grant=0, busy=0, count=0, done=0, rr pointer=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - If req is non-zero, pick the winner: the first set req bit scanning from index ptr upward, wrapping modulo N_REQ.
  - Register the winner's tc into tc_q.
  - Go to RUN with grant=one-hot(winner), count=0.
- RUN:
  - While count != tc_q, count increments by 1 each cycle.
  - When count == tc_q, go to DONE; count holds.
- DONE:
  - done[winner]=1 for exactly this cycle; grant and count hold.
  - Next edge: go to IDLE, grant=0, count=0, ptr=(winner+1) mod N_REQ.
- Arithmetic:
  - count is unsigned WIDTH bits.
  - It stops at tc_q and never wraps; tc_q=2^WIDTH-1 is legal.
- tc=0: the RUN phase lasts one cycle, with count=0 matching immediately.
- tc changes after grant are ignored (tc_q latched).
- Requests arriving during RUN or DONE stay pending and are arbitrated in the next IDLE. None are lost.
- A requester still asserting req after its own done is re-eligible, but ptr has moved past it.
- Reset asserted mid-run: all outputs return to reset values immediately. No done pulse is emitted.

## Timing
- Take the edge at which IDLE samples a non-zero req as edge k.
- Edge k+1: grant valid, busy=1, count=0.
- Edge k+1+tc: count==tc.
- Edges k+2+tc through k+3+tc: done high.
- Edge k+3+tc: grant=0, busy=0.
- Total occupancy is tc+2 cycles of grant. There is one IDLE cycle between back-to-back grants.
- done and grant are registered outputs, with no combinational path from req.

## Configuration
- UPCNT_ARB_ABORT_EN defined:
  - If req[winner] is low at a RUN-state edge, the next state is IDLE; grant=0, count=0, no done pulse, ptr=(winner+1) mod N_REQ.
  - Deassertion in the DONE state is ignored.
- UPCNT_ARB_ABORT_EN undefined:
  - req of the current owner is ignored during RUN/DONE.
  - The run always completes and done always pulses.

## Test plan
- Reset then single request:
  - Stimulus: reset low 10 ns, release; req=0001, tc0=3.
  - Required response: grant=0001 one cycle after sampling; count 0,1,2,3; done=0001 for one cycle; grant=0 next; busy low.
- Round-robin with all four requesting, tc=1 each:
  - Grant order is 0,1,2,3,0.
  - Each grant lasts 3 cycles, with 1 IDLE cycle between grants.
- Boundaries:
  - tc=0: done one cycle after the RUN cycle; count stays 0.
  - tc=15, WIDTH=4: count reaches 15 and holds, with no wrap to 0.
- Pending request:
  - Stimulus: req1 asserted while requester 0 runs tc=5.
  - Required response: requester 1 is granted in the first IDLE after done0; tc change on tc0 mid-run has no effect.
- Reset mid-run:
  - Stimulus: reset low at count=2.
  - Required response: grant, busy, count, done all 0 immediately; after release, arbitration restarts from index 0.
- Abort (UPCNT_ARB_ABORT_EN defined):
  - Stimulus: req0 dropped at count=2 of tc=6.
  - Required response: grant=0 next cycle, no done0, next winner is requester 1.
  - Without the macro, the same stimulus runs to 6 and pulses done0.

Source files
------------

// File: rtl/upcounter_arbiter_if.sv
// ============================================================================
// Module   : upcounter_arbiter_if
// Brief    : Request/grant bundle between requesters and the shared up-counter.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface upcounter_arbiter_if #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
);
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] tc;
  logic [N_REQ-1:0]       grant;
  logic                   busy;
  logic [WIDTH-1:0]       count;
  logic [N_REQ-1:0]       done;

  modport master (
    output req, tc,
    input  grant, busy, count, done
  );

  modport slave (
    input  req, tc,
    output grant, busy, count, done
  );
endinterface

`default_nettype wire

// File: rtl/upcounter_arbiter.sv
// ============================================================================
// Module   : upcounter_arbiter
// Brief    : Round-robin scheduler sharing one up-counter among N_REQ clients.
//            Define UPCNT_ARB_ABORT_EN to let an owner abort its run by
//            dropping req while the counter is running.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module upcounter_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  upcounter_arbiter_if.slave bus
);

  localparam int               PTR_W  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [PTR_W-1:0] C_LAST = PTR_W'(N_REQ - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  state_t             r_state,  w_state_nxt;
  logic [PTR_W-1:0]   r_ptr,    w_ptr_nxt;
  logic [PTR_W-1:0]   r_owner,  w_owner_nxt;
  logic [WIDTH-1:0]   r_tc,     w_tc_nxt;
  logic [WIDTH-1:0]   r_count,  w_count_nxt;
  logic [N_REQ-1:0]   r_grant,  w_grant_nxt;
  logic [N_REQ-1:0]   r_done,   w_done_nxt;
  logic [PTR_W-1:0]   w_winner;
  logic [PTR_W-1:0]   w_scan;
  logic               w_found;
  logic               w_abort;

  // Modulo-N_REQ increment; N_REQ need not be a power of two.
  function automatic logic [PTR_W-1:0] next_idx(input logic [PTR_W-1:0] idx);
    return (idx == C_LAST) ? '0 : idx + 1'b1;
  endfunction

  always_comb begin
    w_found  = 1'b0;
    w_winner = r_ptr;
    w_scan   = r_ptr;
    for (int i = 0; i < N_REQ; i++) begin
      if (!w_found && bus.req[w_scan]) begin
        w_found  = 1'b1;
        w_winner = w_scan;
      end
      w_scan = next_idx(w_scan);
    end
  end

`ifdef UPCNT_ARB_ABORT_EN
  assign w_abort = (r_state == ST_RUN) && !bus.req[r_owner];
`else
  assign w_abort = 1'b0;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_owner_nxt = r_owner;
    w_tc_nxt    = r_tc;
    w_count_nxt = r_count;
    w_grant_nxt = r_grant;
    w_done_nxt  = '0;
    case (r_state)
      ST_IDLE: begin
        if (w_found) begin
          w_state_nxt           = ST_RUN;
          w_owner_nxt           = w_winner;
          w_tc_nxt              = bus.tc[w_winner*WIDTH +: WIDTH];
          w_count_nxt           = '0;
          w_grant_nxt           = '0;
          w_grant_nxt[w_winner] = 1'b1;
        end
      end
      ST_RUN: begin
        if (w_abort) begin
          w_state_nxt = ST_IDLE;
          w_grant_nxt = '0;
          w_count_nxt = '0;
          w_ptr_nxt   = next_idx(r_owner);
        end else if (r_count == r_tc) begin
          // Counter holds at the terminal value; it never wraps.
          w_state_nxt = ST_DONE;
          w_done_nxt  = r_grant;
        end else begin
          w_count_nxt = r_count + 1'b1;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_count_nxt = '0;
        w_ptr_nxt   = next_idx(r_owner);
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_grant_nxt = '0;
        w_count_nxt = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_owner <= '0;
      r_tc    <= '0;
      r_count <= '0;
      r_grant <= '0;
      r_done  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_owner <= w_owner_nxt;
      r_tc    <= w_tc_nxt;
      r_count <= w_count_nxt;
      r_grant <= w_grant_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign bus.grant = r_grant;
  assign bus.busy  = (r_state != ST_IDLE);
  assign bus.count = r_count;
  assign bus.done  = r_done;

endmodule

`default_nettype wire

// File: tb/tb_upcounter_arbiter.sv
// ============================================================================
// Module   : tb_upcounter_arbiter
// Brief    : Scoreboard bench: a timeline model predicts every cycle's outputs.
// Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_upcounter_arbiter;

  localparam int N      = 4;
  localparam int W      = 4;
  localparam int TC_MAX = (1 << W) - 1;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  upcounter_arbiter_if #(.N_REQ(N), .WIDTH(W)) bus ();

  upcounter_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [N-1:0] grant;
    logic         busy;
    logic [W-1:0] count;
    logic [N-1:0] done;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   hold_req  = 1'b0;
  bit   rand_mode = 1'b0;

  // Reference timeline: a grant taken at edge g occupies edges g..g+1+tc,
  // done shows after edge g+1+tc, and the next arbitration is at g+3+tc.
  bit m_act;
  int m_who, m_tc, m_g, m_ptr, m_free;

  always @(posedge clk) begin
    exp_t e;
    int   c;
    bit   f;
    cyc++;
    if (!reset) begin
      m_act  = 1'b0;
      m_ptr  = 0;
      m_free = 0;
      exp_q.delete();
    end else begin
      if (m_act) begin
`ifdef UPCNT_ARB_ABORT_EN
        if (cyc > m_g && cyc <= m_g + 1 + m_tc && !bus.req[m_who]) begin
          m_act  = 1'b0;
          m_ptr  = (m_who + 1) % N;
          m_free = cyc + 1;
        end
`endif
        if (m_act && cyc == m_g + 2 + m_tc) begin
          m_act = 1'b0;
          m_ptr = (m_who + 1) % N;
        end
      end
      if (!m_act && cyc >= m_free && bus.req != '0) begin
        f = 1'b0;
        for (int k = 0; k < N; k++) begin
          c = (m_ptr + k) % N;
          if (!f && bus.req[c]) begin
            f     = 1'b1;
            m_who = c;
          end
        end
        m_tc   = int'(bus.tc[m_who*W +: W]);
        m_g    = cyc;
        m_act  = 1'b1;
        m_free = cyc + 3 + m_tc;
      end
      e.grant = '0;
      e.busy  = 1'b0;
      e.count = '0;
      e.done  = '0;
      if (m_act) begin
        e.grant[m_who] = 1'b1;
        e.busy         = 1'b1;
        e.count        = W'((cyc - m_g < m_tc) ? cyc - m_g : m_tc);
        e.done         = (cyc == m_g + 1 + m_tc) ? e.grant : '0;
      end
      exp_q.push_back(e);
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (!reset) begin
      checks++;
      if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.count !== '0 || bus.done !== '0) begin
        errors++;
        $display("FAIL reset_state t=%0t: grant=%b busy=%b count=%0d done=%b, required all zero",
                 $time, bus.grant, bus.busy, bus.count, bus.done);
      end
    end else if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      checks++;
      if (bus.grant !== e.grant || bus.busy !== e.busy ||
          bus.count !== e.count || bus.done !== e.done) begin
        errors++;
        $display("FAIL cycle %0d: got grant=%b busy=%b count=%0d done=%b, required grant=%b busy=%b count=%0d done=%b",
                 cyc, bus.grant, bus.busy, bus.count, bus.done,
                 e.grant, e.busy, e.count, e.done);
      end
    end
  end

  task automatic drive_cycle();
    @(negedge clk);
    for (int i = 0; i < N; i++) begin
      if (bus.done[i] && !hold_req) bus.req[i] = 1'b0;
      if (rand_mode) begin
        if (!bus.req[i] && $urandom_range(0, 5) == 0) begin
          bus.tc[i*W +: W] = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, TC_MAX))
                                                          : W'($urandom_range(0, 4));
          bus.req[i] = 1'b1;
        end else if ($urandom_range(0, 15) == 0) begin
          bus.tc[i*W +: W] = W'($urandom_range(0, TC_MAX));
        end
      end
    end
  endtask

  task automatic request(input int i, input int t);
    bus.tc[i*W +: W] = W'(t);
    bus.req[i]       = 1'b1;
  endtask

  task automatic run_cycles(input int n);
    repeat (n) drive_cycle();
  endtask

  task automatic wait_quiet(input int limit, input string tag);
    int n;
    n = 0;
    do begin
      drive_cycle();
      n++;
    end while ((bus.req != '0 || bus.busy) && n < limit);
    checks++;
    if (bus.req != '0 || bus.busy) begin
      errors++;
      $display("FAIL %s_timeout: req=%b busy=%b after %0d cycles, required both idle",
               tag, bus.req, bus.busy, n);
    end
  endtask

  task automatic wait_count(input int val, input int limit, input string tag);
    int n;
    n = 0;
    do begin
      drive_cycle();
      n++;
    end while (!(bus.busy && int'(bus.count) == val) && n < limit);
    checks++;
    if (!(bus.busy && int'(bus.count) == val)) begin
      errors++;
      $display("FAIL %s_wait: count=%0d busy=%b after %0d cycles, required count=%0d while busy",
               tag, bus.count, bus.busy, n, val);
    end
  endtask

  initial begin
    bus.req = '0;
    bus.tc  = '0;
    reset   = 1'b0;
    #12 reset = 1'b1;

    drive_cycle();
    request(0, 3);
    wait_quiet(40, "single");

    // All four held with tc=1: order 0,1,2,3,0 then each drops after its done.
    hold_req = 1'b1;
    for (int i = 0; i < N; i++) request(i, 1);
    run_cycles(18);
    hold_req = 1'b0;
    wait_quiet(60, "round_robin");

    request(2, 0);
    wait_quiet(20, "tc_zero");
    request(3, TC_MAX);
    wait_quiet(40, "tc_max");

    // Pending request plus a tc change on the running owner.
    request(0, 5);
    run_cycles(2);
    request(1, 2);
    run_cycles(1);
    bus.tc[0*W +: W] = W'(1);
    wait_quiet(40, "pending");

    // Reset mid-run with ptr parked at 3; restart must scan from 0.
    request(2, 2);
    wait_quiet(20, "prep");
    request(2, 9);
    wait_count(1, 20, "rst_mid");
    request(1, 3);
    request(3, 3);
    wait_count(2, 20, "rst_mid");
    #2 reset = 1'b0;
    #1;
    checks++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.count !== '0 || bus.done !== '0) begin
      errors++;
      $display("FAIL reset_immediate: grant=%b busy=%b count=%0d done=%b, required all zero",
               bus.grant, bus.busy, bus.count, bus.done);
    end
    @(negedge clk);
    #2 reset = 1'b1;
    wait_quiet(80, "after_reset");

    // Owner drops req at count 2 of a tc=6 run.
    request(0, 6);
    drive_cycle();
    request(1, 1);
    wait_count(2, 20, "abort");
    bus.req[0] = 1'b0;
    wait_quiet(40, "abort");

    rand_mode = 1'b1;
    run_cycles(3000);
    rand_mode = 1'b0;
    wait_quiet(300, "drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, required completion before 1 ms");
    $fatal(1, "watchdog expired");
  end

endmodule

`default_nettype wire
